qs_fifo_push_arb: RTL and testbench

//  Round-robin write arbiter sharing one qs_fifo among NUM_REQ producers.

---
 rtl/qs_fifo_pkg.sv | 25 ++
 rtl/qs_rr_picker.sv | 47 ++++
 rtl/qs_fifo_push_arb.sv | 111 +++++++++++
 tb/tb_qs_fifo_push_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qs_fifo_pkg.sv
// Shared constants and width helpers for qs_fifo and the blocks that sit in front of it.
//
// Contents:
//   clog2_min1(n)     ceil(log2(n)), never less than 1, so a one-entry index still has a bit
//   cnt_width(max)    width of a counter that must hold 0..max inclusive
//   Def*              default geometry used by the FIFO and its push arbiter
package qs_fifo_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = $clog2(n);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return clog2_min1(max_val + 1);
  endfunction

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefNumReq   = 4;
  localparam int unsigned DefMaxBurst = 4;
  localparam int unsigned DefIdW      = clog2_min1(DefNumReq);
  localparam int unsigned DefCntW     = cnt_width(DefMaxBurst);

endpackage

// File: rtl/qs_rr_picker.sv
// Combinational round-robin picker.
//
// Finds the first set bit of req, scanning upward from index start and wrapping modulo N.
//
// Ports:
//   req    in   N   request vector
//   start  in   W   index that is checked first
//   found  out  1   at least one request bit is set
//   idx    out  W   index of the winning request (0 when none)
module qs_rr_picker
  import qs_fifo_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  int unsigned  sum;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to req[start].
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[W'((32'(start) + 32'(i)) % N)];
    end

    // Find-first: walking downward leaves the lowest set offset in off.
    found = |rot;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = W'(i);
      end
    end

    // Unrotate back to an absolute producer index.
    sum = (32'(start) + 32'(off)) % N;
    idx = found ? W'(sum) : '0;
  end

endmodule

// File: rtl/qs_fifo_push_arb.sv
// Round-robin write arbiter sharing one qs_fifo write port among NUM_REQ producers.
//
// A producer that wins a grant keeps the FIFO for up to MAX_BURST consecutive beats as long
// as it stays valid; afterwards the search resumes at the next producer in round-robin order.
// Handshake is zero-latency: all outputs are combinational from state and inputs.
//
// Ports:
//   clk            in   1               rising-edge clock
//   reset          in   1               asynchronous, active-high reset
//   req_valid_i    in   NUM_REQ         per-producer data valid
//   req_data_i     in   NUM_REQ*DATA_W  producer n data at [n*DATA_W +: DATA_W]
//   req_ready_o    out  NUM_REQ         one-hot (or zero): beat of producer n accepted
//   push_o         out  1               to FIFO push_i
//   push_data_o    out  DATA_W          to FIFO push_data_i
//   full_i         in   1               from FIFO full_o
//   grant_valid_o  out  1               a producer is granted this cycle
//   grant_id_o     out  ID_W            index of granted producer (0 when none)
module qs_fifo_push_arb
  import qs_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned NUM_REQ   = DefNumReq,
  parameter int unsigned MAX_BURST = DefMaxBurst,
  localparam int unsigned ID_W     = clog2_min1(NUM_REQ),
  localparam int unsigned CNT_W    = cnt_width(MAX_BURST)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      push_o,
  output logic [DATA_W-1:0]         push_data_o,
  input  logic                      full_i,
  output logic                      grant_valid_o,
  output logic [ID_W-1:0]           grant_id_o
);

  // owner_q: producer that made the most recent transfer.
  // burst_cnt_q: beats that owner has moved in its current burst (0 only after reset).
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [ID_W-1:0]  start_idx;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;
  logic [ID_W-1:0]  grant;
  logic             locked;
  logic             xfer;

  // Search begins just after the current owner, so the owner is considered last.
  assign start_idx = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

  qs_rr_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req   (req_valid_i),
    .start (start_idx),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The lock is released the same cycle the owner drops valid or its count saturates,
  // so the picker result is used without a bubble. With MAX_BURST=1 it can never hold.
  assign locked = (burst_cnt_q != '0) && (burst_cnt_q < CNT_W'(MAX_BURST)) &&
                  req_valid_i[owner_q];

  assign grant = locked ? owner_q : pick_idx;

  always_comb begin
    grant_valid_o = pick_found && !reset;
    xfer          = grant_valid_o && !full_i;
    push_o        = xfer;
    grant_id_o    = grant_valid_o ? grant : '0;

    push_data_o = '0;
    req_ready_o = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (grant_valid_o && (grant == ID_W'(n))) begin
        push_data_o    = req_data_i[n*DATA_W +: DATA_W];
        req_ready_o[n] = xfer;
      end
    end
  end

  // State moves only on an actual transfer; a burst stalled by full_i keeps its count.
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer) begin
      if (locked) begin
        burst_cnt_d = burst_cnt_q + CNT_W'(1);
      end else begin
        owner_d     = grant;
        burst_cnt_d = CNT_W'(1);
      end
    end
  end

  // Owner resets to the last index so producer 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q     <= ID_W'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_qs_fifo_push_arb.sv
// Bench for qs_fifo_push_arb: one instance with MAX_BURST=4, one with MAX_BURST=1, both fed
// the same producer and full inputs. A behavioural arbitration model tracks each instance.
module tb_qs_fifo_push_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  vld;
  logic [31:0] dat;
  logic        full;

  logic [3:0]  rdy0, rdy1;
  logic        push0, push1, gv0, gv1;
  logic [7:0]  pd0, pd1;
  logic [1:0]  gid0, gid1;

  always #5 clk = ~clk;

  qs_fifo_push_arb #(
    .DATA_W    (8),
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (vld),
    .req_data_i    (dat),
    .req_ready_o   (rdy0),
    .push_o        (push0),
    .push_data_o   (pd0),
    .full_i        (full),
    .grant_valid_o (gv0),
    .grant_id_o    (gid0)
  );

  qs_fifo_push_arb #(
    .DATA_W    (8),
    .NUM_REQ   (4),
    .MAX_BURST (1)
  ) u_dut_rr (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (vld),
    .req_data_i    (dat),
    .req_ready_o   (rdy1),
    .push_o        (push1),
    .push_data_o   (pd1),
    .full_i        (full),
    .grant_valid_o (gv1),
    .grant_id_o    (gid1)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         m_owner[2];
  int         m_cnt[2];
  int         hist0[$];
  int         hist1[$];
  logic [7:0] fifo_q[$];
  int         beat[4];
  int         exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int got[$], input int exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
    end
  endtask

  // Behavioural rule: keep the owner while its burst is running and it is still valid,
  // otherwise take the first valid producer after the owner, wrapping round.
  function automatic void model(input int k, input logic [3:0] v,
                                output bit gv, output bit lk, output int g);
    int  mb;
    int  o;
    bit  f;
    mb = (k == 0) ? 4 : 1;
    o  = m_owner[k];
    gv = |v;
    lk = (m_cnt[k] > 0) && (m_cnt[k] < mb) && v[o];
    g  = 0;
    f  = 0;
    if (lk) begin
      g = o;
    end else begin
      for (int i = 1; i <= 4; i++) begin
        if (!f && v[(o + i) % 4]) begin
          f = 1;
          g = (o + i) % 4;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 3;
      m_cnt[k]   = 0;
    end
  endfunction

  // One clock cycle: drive inputs after the falling edge, check, then let the edge commit.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input bit f);
    bit gv, lk, ep;
    int g;
    bit lks[2];
    bit eps[2];
    int gs[2];
    vld  = v;
    dat  = d;
    full = f;
    #1;
    for (int k = 0; k < 2; k++) begin
      model(k, v, gv, lk, g);
      ep     = gv && !f;
      lks[k] = lk;
      eps[k] = ep;
      gs[k]  = g;
      check($sformatf("push%0d", k), (k == 0) ? push0 : push1, ep);
      check($sformatf("gvalid%0d", k), (k == 0) ? gv0 : gv1, gv);
      check($sformatf("gid%0d", k), (k == 0) ? gid0 : gid1, gv ? g : 0);
      check($sformatf("ready%0d", k), (k == 0) ? rdy0 : rdy1, ep ? (32'd1 << g) : 32'd0);
      check($sformatf("pdata%0d", k), (k == 0) ? pd0 : pd1, gv ? d[g*8 +: 8] : 8'h00);
    end
    if (push0) begin
      hist0.push_back(int'(gid0));
      fifo_q.push_back(pd0);
      beat[gid0]++;
    end
    if (push1) hist1.push_back(int'(gid1));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (eps[k]) begin
        if (lks[k]) begin
          m_cnt[k]++;
        end else begin
          m_owner[k] = gs[k];
          m_cnt[k]   = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset pulse; outputs must drop before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_push0", push0, 0);
    check("rst_push1", push1, 0);
    check("rst_ready0", rdy0, 0);
    check("rst_ready1", rdy1, 0);
    check("rst_gvalid0", gv0, 0);
    check("rst_gvalid1", gv1, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    hist0.delete();
    hist1.delete();
    fifo_q.delete();
    for (int n = 0; n < 4; n++) beat[n] = 0;
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1;
    vld   = 4'hF;
    dat   = 32'h0;
    full  = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single producer 2 streams three words.
    step(4'b0100, 32'hA0 << 16, 1'b0);
    step(4'b0100, 32'hA1 << 16, 1'b0);
    step(4'b0100, 32'hA2 << 16, 1'b0);
    step(4'b0000, 32'h0, 1'b0);
    exp_q = '{2, 2, 2};
    check_seq("t1_grants", hist0, exp_q);
    check("t1_len", fifo_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_pop%0d", i), (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'hxx,
            32'hA0 + i);
    end

    // All producers valid until the 16-entry FIFO fills.
    do_reset();
    for (int t = 0; t < 20; t++) begin
      for (int n = 0; n < 4; n++) d[n*8 +: 8] = {4'(n), 4'(beat[n])};
      step(4'hF, d, fifo_q.size() >= 16);
    end
    exp_q = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
    check_seq("t2_grants", hist0, exp_q);
    while (hist1.size() > 6) void'(hist1.pop_back());
    exp_q = '{0, 1, 2, 3, 0, 1};
    check_seq("t6_rr", hist1, exp_q);
    vld  = 4'hF;
    full = 1'b1;
    #1;
    check("t2_full_push", push0, 0);
    check("t2_full_ready", rdy0, 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_pop%0d", i), (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'hxx,
            ((i / 4) << 4) | (i % 4));
    end

    // Owner 1 drops valid after two beats; producer 2 takes over with a fresh count.
    do_reset();
    step(4'b1110, 32'h33221100, 1'b0);
    step(4'b1110, 32'h33221100, 1'b0);
    step(4'b1100, 32'h33221100, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b1110, 32'h33221100, 1'b0);
    exp_q = '{1, 1, 2, 2, 2, 2, 3};
    check_seq("t3_grants", hist0, exp_q);

    // Burst of producer 0 stalled by full keeps its count.
    do_reset();
    step(4'hF, 32'h33221100, 1'b0);
    step(4'hF, 32'h33221100, 1'b0);
    for (int i = 0; i < 3; i++) step(4'hF, 32'h33221100, 1'b1);
    for (int i = 0; i < 3; i++) step(4'hF, 32'h33221100, 1'b0);
    exp_q = '{0, 0, 0, 0, 1};
    check_seq("t4_grants", hist0, exp_q);

    // Reset lands during the third beat of a burst.
    do_reset();
    step(4'hF, 32'h33221100, 1'b0);
    step(4'hF, 32'h33221100, 1'b0);
    vld = 4'hF;
    #1;
    check("t5_push_before", push0, 1);
    do_reset();
    step(4'hF, 32'h33221100, 1'b0);
    exp_q = '{0};
    check_seq("t5_grants", hist0, exp_q);

    // Lone producer 3 wins every cycle, including across a saturated burst.
    do_reset();
    for (int i = 0; i < 6; i++) step(4'b1000, 32'h5A000000, 1'b0);
    exp_q = '{3, 3, 3, 3, 3, 3};
    check_seq("t6_lone0", hist0, exp_q);
    check_seq("t6_lone1", hist1, exp_q);

    // Random traffic against the model.
    do_reset();
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      step(4'($urandom), $urandom, $urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
